// File: rtl/octa_wb_pkg.sv
// Shared types and constants for the writeback arbiter and register scoreboard.
// Contents: register-file geometry, grant-pointer enum, writeback request
// payload and a one-hot decode helper for register indices.
package octa_wb_pkg;

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned ADDR_WIDTH = 3;
   localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

   // Identifies which writeback path was granted most recently.
   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wb_src_t;

   // Destination register and result carried by one writeback request.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0] data;
   } wb_req_t;

   // One-hot decode of a register index.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_WIDTH-1:0] idx);
      reg_onehot = NUM_REGS'(1) << idx;
   endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Register scoreboard: tracks destination registers with a write still in
// flight and raises a combinational stall for RAW/WAW hazards at decode.
// Build option: WB_BYPASS_EN lets the register being written this cycle
// count as free in the hazard compare.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   iss_valid              decode presents an instruction
//   iss_rd/iss_rs1/iss_rs2 destination and sources of that instruction
//   wr_en, wr_rd           register-file write in progress (clears busy)
//   hazard                 combinational stall to decode
module wb_scoreboard
   import octa_wb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   input  logic [ADDR_WIDTH-1:0] iss_rs1,
   input  logic [ADDR_WIDTH-1:0] iss_rs2,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_rd,
   output logic                  hazard
);

   logic [NUM_REGS-1:1] busy_q;
   logic [NUM_REGS-1:0] busy_vec;
   logic [NUM_REGS-1:0] clr_vec;
   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] hz_vec;
   logic [NUM_REGS-1:0] busy_nxt;
   logic                accept;

   // r0 is never busy, so bit 0 is tied low.
   assign busy_vec = {busy_q, 1'b0};

   // Hazard compare and next busy vector; a set overrides a clear on the same index.
   always_comb begin
      clr_vec = '0;
      if (wr_en) begin
         clr_vec = reg_onehot(wr_rd);
      end
`ifdef WB_BYPASS_EN
      hz_vec = busy_vec & ~clr_vec;
`else
      hz_vec = busy_vec;
`endif
      hazard  = !rst && iss_valid && (hz_vec[iss_rs1] || hz_vec[iss_rs2] || hz_vec[iss_rd]);
      accept  = iss_valid && !hazard && !rst;
      set_vec = '0;
      if (accept) begin
         set_vec = reg_onehot(iss_rd);
      end
      busy_nxt = (busy_vec & ~clr_vec) | set_vec;
   end

   // Busy register.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_nxt[NUM_REGS-1:1];
      end
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: shares the single register-file write port between the
// ALU and load writeback paths with round-robin priority, registers the
// winning write, and delivers decode operands (optionally bypassing the write
// in flight). Hazard tracking lives in wb_scoreboard.
// Build option: WB_BYPASS_EN forwards rf_din to op_r1/op_r2 and relaxes the
// hazard compare for the register being written.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/alu_ready/rd/data   ALU writeback handshake (ready combinational)
//   mem_valid/mem_ready/rd/data   load writeback handshake (ready combinational)
//   rf_wr_en, rf_rd, rf_din       registered register-file write port
//   iss_valid, iss_rd/rs1/rs2     instruction presented by decode
//   hazard                        combinational stall to decode
//   rf_r1, rf_r2                  register-file read data for rs1/rs2
//   op_r1, op_r2                  operands delivered to execute
module reg_wb_arbiter
   import octa_wb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [ADDR_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  rf_wr_en,
   output logic [ADDR_WIDTH-1:0] rf_rd,
   output logic [DATA_WIDTH-1:0] rf_din,
   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   input  logic [ADDR_WIDTH-1:0] iss_rs1,
   input  logic [ADDR_WIDTH-1:0] iss_rs2,
   output logic                  hazard,
   input  logic [DATA_WIDTH-1:0] rf_r1,
   input  logic [DATA_WIDTH-1:0] rf_r2,
   output logic [DATA_WIDTH-1:0] op_r1,
   output logic [DATA_WIDTH-1:0] op_r2
);

   wb_src_t last_q;
   wb_req_t alu_req;
   wb_req_t mem_req;
   wb_req_t win_req;
   logic    xfer;

   // Round-robin grant: on a conflict the path not granted last time wins.
   always_comb begin
      alu_req.rd   = alu_rd;
      alu_req.data = alu_data;
      mem_req.rd   = mem_rd;
      mem_req.data = mem_data;
      alu_ready    = !rst && alu_valid && (!mem_valid || (last_q == WB_MEM));
      mem_ready    = !rst && mem_valid && (!alu_valid || (last_q == WB_ALU));
      xfer         = alu_ready || mem_ready;
      win_req      = mem_ready ? mem_req : alu_req;
   end

   // Grant pointer and write-port output register; writes to r0 are swallowed.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q   <= WB_ALU;
         rf_wr_en <= 1'b0;
         rf_rd    <= '0;
         rf_din   <= '0;
      end else begin
         rf_wr_en <= xfer && (win_req.rd != '0);
         if (alu_ready) begin
            last_q <= WB_ALU;
         end else if (mem_ready) begin
            last_q <= WB_MEM;
         end
         if (xfer && (win_req.rd != '0)) begin
            rf_rd  <= win_req.rd;
            rf_din <= win_req.data;
         end
      end
   end

   // Operand muxes.
   always_comb begin
      op_r1 = rf_r1;
      op_r2 = rf_r2;
`ifdef WB_BYPASS_EN
      if (rf_wr_en && (iss_rs1 == rf_rd) && (iss_rs1 != '0)) begin
         op_r1 = rf_din;
      end
      if (rf_wr_en && (iss_rs2 == rf_rd) && (iss_rs2 != '0)) begin
         op_r2 = rf_din;
      end
`endif
   end

   wb_scoreboard u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .wr_en     (rf_wr_en),
      .wr_rd     (rf_rd),
      .hazard    (hazard)
   );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: table of writeback vectors with hand-derived
// grants, a queue of expected register-file writes, and hand-written
// sequences for hazard timing, set-over-clear and mid-operation reset.
module tb_reg_wb_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       alu_valid, alu_ready, mem_valid, mem_ready;
   logic [2:0] alu_rd, mem_rd;
   logic [7:0] alu_data, mem_data;
   logic       rf_wr_en;
   logic [2:0] rf_rd;
   logic [7:0] rf_din;
   logic       iss_valid, hazard;
   logic [2:0] iss_rd, iss_rs1, iss_rs2;
   logic [7:0] rf_r1, rf_r2, op_r1, op_r2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       av;
      logic [2:0] ard;
      logic [7:0] adat;
      logic       mv;
      logic [2:0] mrd;
      logic [7:0] mdat;
      logic       ear;
      logic       emr;
   } vec_t;

   typedef struct {
      logic       wr_en;
      logic [2:0] rd;
      logic [7:0] din;
   } rf_exp_t;

   vec_t    vecs [11];
   rf_exp_t exp_q [$];

   always #5 clk = ~clk;

   reg_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .rf_wr_en  (rf_wr_en),
      .rf_rd     (rf_rd),
      .rf_din    (rf_din),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .hazard    (hazard),
      .rf_r1     (rf_r1),
      .rf_r2     (rf_r2),
      .op_r1     (op_r1),
      .op_r2     (op_r2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: check combinational outputs mid-cycle, queue the expected
   // write, then compare the registered write port after the edge.
   task automatic run_cycle(input string tag, input logic ear, input logic emr,
                            input logic ehaz, input logic [7:0] eop1, input logic [7:0] eop2);
      rf_exp_t e;
      rf_exp_t g;
      @(negedge clk);
      chk({tag, " alu_ready"}, 32'(alu_ready), 32'(ear));
      chk({tag, " mem_ready"}, 32'(mem_ready), 32'(emr));
      chk({tag, " hazard"},    32'(hazard),    32'(ehaz));
      chk({tag, " op_r1"},     32'(op_r1),     32'(eop1));
      chk({tag, " op_r2"},     32'(op_r2),     32'(eop2));
      if (ear && alu_rd != 3'd0)      e = '{1'b1, alu_rd, alu_data};
      else if (emr && mem_rd != 3'd0) e = '{1'b1, mem_rd, mem_data};
      else                            e = '{1'b0, 3'd0, 8'd0};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard: got empty queue expected entry", tag);
      end else begin
         g = exp_q.pop_front();
         chk({tag, " rf_wr_en"}, 32'(rf_wr_en), 32'(g.wr_en));
         if (g.wr_en) begin
            chk({tag, " rf_rd"},  32'(rf_rd),  32'(g.rd));
            chk({tag, " rf_din"}, 32'(rf_din), 32'(g.din));
         end
      end
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_rd = 3'd0; alu_data = 8'h00;
      mem_valid = 1'b0; mem_rd = 3'd0; mem_data = 8'h00;
      iss_valid = 1'b0; iss_rd = 3'd0; iss_rs1 = 3'd0; iss_rs2 = 3'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Grants derived by hand from the round-robin rule, starting with last-grant = alu.
      vecs[0]  = '{1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 3'd2, 8'h22, 1'b1, 3'd1, 8'h11, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 3'd2, 8'h22, 1'b1, 3'd4, 8'h44, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 3'd6, 8'h66, 1'b1, 3'd4, 8'h44, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 3'd6, 8'h66, 1'b1, 3'd7, 8'h77, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'hFF, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 3'd5, 8'h55, 1'b1, 3'd3, 8'h33, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 3'd5, 8'h55, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0};

      rf_r1 = 8'h10;
      rf_r2 = 8'h20;
      idle_inputs();

      // Reset with requests and an instruction present: readies and hazard low.
      rst = 1'b1;
      alu_valid = 1'b1; alu_rd = 3'd1; mem_valid = 1'b1; mem_rd = 3'd2;
      iss_valid = 1'b1; iss_rs1 = 3'd1;
      run_cycle("rst0", 1'b0, 1'b0, 1'b0, 8'h10, 8'h20);
      run_cycle("rst1", 1'b0, 1'b0, 1'b0, 8'h10, 8'h20);
      rst = 1'b0;
      idle_inputs();

      // Writeback vectors.
      for (int i = 0; i < 11; i++) begin
         alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
         mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].mdat;
         run_cycle($sformatf("vec%0d", i), vecs[i].ear, vecs[i].emr, 1'b0, 8'h10, 8'h20);
      end
      idle_inputs();

      // RAW on r5: issue, wait, write back 8'h3C, watch hazard release.
      iss_valid = 1'b1; iss_rd = 3'd5;
      run_cycle("raw_issue", 1'b0, 1'b0, 1'b0, 8'h10, 8'h20);
      iss_rd = 3'd0; iss_rs1 = 3'd5;
      run_cycle("raw_wait", 1'b0, 1'b0, 1'b1, 8'h10, 8'h20);
      alu_valid = 1'b1; alu_rd = 3'd5; alu_data = 8'h3C;
      run_cycle("raw_xfer", 1'b1, 1'b0, 1'b1, 8'h10, 8'h20);
      alu_valid = 1'b0; alu_rd = 3'd0; alu_data = 8'h00;
`ifdef WB_BYPASS_EN
      run_cycle("raw_n1", 1'b0, 1'b0, 1'b0, 8'h3C, 8'h20);
`else
      run_cycle("raw_n1", 1'b0, 1'b0, 1'b1, 8'h10, 8'h20);
`endif
      run_cycle("raw_n2", 1'b0, 1'b0, 1'b0, 8'h10, 8'h20);
      idle_inputs();

      // Issue to r2 in the cycle r2 is being written: set beats clear.
      alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 8'h5A;
      run_cycle("sw_xfer", 1'b1, 1'b0, 1'b0, 8'h10, 8'h20);
      idle_inputs();
      iss_valid = 1'b1; iss_rd = 3'd2;
      run_cycle("sw_issue", 1'b0, 1'b0, 1'b0, 8'h10, 8'h20);
      iss_rd = 3'd0; iss_rs1 = 3'd2;
      run_cycle("sw_check", 1'b0, 1'b0, 1'b1, 8'h10, 8'h20);
      run_cycle("sw_hold", 1'b0, 1'b0, 1'b1, 8'h10, 8'h20);
      idle_inputs();

      // Reset with busy r4 (and r2), a pending write and last-grant = mem.
      iss_valid = 1'b1; iss_rd = 3'd4;
      run_cycle("rc_issue", 1'b0, 1'b0, 1'b0, 8'h10, 8'h20);
      idle_inputs();
      mem_valid = 1'b1; mem_rd = 3'd6; mem_data = 8'h99;
      run_cycle("rc_xfer", 1'b0, 1'b1, 1'b0, 8'h10, 8'h20);
      rst = 1'b1;
      alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 8'h01;
      mem_valid = 1'b1; mem_rd = 3'd7; mem_data = 8'h70;
      iss_valid = 1'b1; iss_rd = 3'd0; iss_rs1 = 3'd4; iss_rs2 = 3'd0;
      run_cycle("rc_rst", 1'b0, 1'b0, 1'b0, 8'h10, 8'h20);
      rst = 1'b0;
      iss_rs2 = 3'd2;
      run_cycle("rc_after", 1'b0, 1'b1, 1'b0, 8'h10, 8'h20);
      idle_inputs();
      run_cycle("rc_idle", 1'b0, 1'b0, 1'b0, 8'h10, 8'h20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
